engine_sequencer: RTL and testbench
===================================

ENGINE_SEQUENCER -- requirements
Module: engine_sequencer

Interface
REQ-001 The module SHALL have parameter NUM_ENG, default 4, meaning the number of sequenced engines (legal range 1..32).
REQ-002 The module SHALL have parameter RST_CYCLES, default 4, meaning the length in cycles of the engine reset phase (legal range 1..255).
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the watchdog limit in cycles (legal range 2..65535).
REQ-004 The module SHALL have port HCLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port HRESET, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port cfg_reset, input, 32 bits: level per engine, taken from the reset control register.
REQ-007 The module SHALL have port cfg_start, input, 32 bits: level per engine, taken from the start control register.
REQ-008 The module SHALL have port eng_done, input, NUM_ENG bits: per-engine completion, level or pulse.
REQ-009 The module SHALL have port eng_rst, output, NUM_ENG bits: per-engine reset.
REQ-010 The module SHALL have port eng_start, output, NUM_ENG bits: per-engine start, a 1-cycle pulse.
REQ-011 The module SHALL have port finished, output, 32 bits: sticky per-engine completion flags, feeding the finished status register.
REQ-012 The module SHALL have port timeout, output, 32 bits: sticky per-engine watchdog flags.
REQ-013 The module SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-014 The module SHALL have port cur_eng, output, 5 bits: index of the granted engine, or 0 when the FSM is in IDLE.

Function
REQ-015 A 0->1 edge on cfg_start[i] (i<NUM_ENG) SHALL set pending[i] and clear finished[i] and timeout[i] on the following edge; a held level SHALL NOT re-trigger.
REQ-016 The FSM SHALL have exactly these states: IDLE, RST, START, WAIT, DONE; one engine is granted at a time (the datapath is shared).
REQ-017 IDLE: if any pending bit is set, the FSM SHALL grant the first pending index searching round-robin from last_grant+1 (wrapping at NUM_ENG-1 to 0), clear that pending bit, and enter RST on the next cycle.
REQ-018 RST: eng_rst[g] SHALL be high for exactly RST_CYCLES cycles, after which the FSM SHALL enter START.
REQ-019 START: eng_start[g] SHALL be high for exactly 1 cycle, after which the FSM SHALL enter WAIT.
REQ-020 eng_done is not sampled in START, so a done asserted during the start-pulse cycle SHALL be ignored.
REQ-021 WAIT: eng_done[g]=1 SHALL move the FSM to DONE.
REQ-022 eng_done[j] with j!=g SHALL be ignored in every state.
REQ-023 DONE: the FSM SHALL set finished[g], set last_grant to g, and return to IDLE, all in 1 cycle.
REQ-024 Minimum latency from the start edge to the eng_start pulse SHALL be RST_CYCLES+2 cycles when the FSM is idle.
REQ-025 cfg_reset[i]=1 SHALL hold eng_rst[i] high, clear pending[i], finished[i] and timeout[i], and block new edges on cfg_start[i].
REQ-026 If cfg_reset[g] asserts while engine g is granted, the FSM SHALL abort to IDLE on the next cycle without setting finished[g].
REQ-027 When cfg_reset[i] and a cfg_start[i] edge occur in the same cycle, reset SHALL win and pending[i] SHALL stay 0.
REQ-028 Bits NUM_ENG..31 of cfg_reset and cfg_start SHALL be ignored.
REQ-029 Bits NUM_ENG..31 of finished and timeout SHALL read as 0.
REQ-030 eng_rst[i] SHALL equal (cfg_reset[i] OR (state==RST AND g==i)).
REQ-031 The round-robin grant SHALL make starvation impossible: a pending engine is granted within NUM_ENG grants.

Reset
REQ-032 With HRESET=1 at a clock edge, the FSM SHALL enter IDLE and pending, finished, timeout, eng_start, busy, cur_eng and the counters SHALL become 0.
REQ-033 After HRESET, last_grant SHALL be NUM_ENG-1, so that engine 0 has first priority.
REQ-034 During HRESET, eng_rst SHALL be all ones; it follows REQ-030 from the first cycle after release.
REQ-035 An HRESET asserted mid-sequence SHALL abandon the grant with no finished or timeout update.
REQ-036 Start edges SHALL be detected against a previous-value register that is cleared by HRESET, so a cfg_start bit already high at release SHALL count as an edge.

Configuration
REQ-037 With macro SEQ_TIMEOUT_EN defined, a 16-bit counter SHALL count cycles spent in WAIT.
REQ-038 With SEQ_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without done SHALL set timeout[g] and move the FSM to IDLE, leaving finished[g]=0 and not updating last_grant.
REQ-039 With SEQ_TIMEOUT_EN undefined, there SHALL be no counter, WAIT SHALL wait indefinitely, and timeout SHALL be tied to 0.

Verification
REQ-040 The bench SHALL cover: cfg_start=0x1, eng_done[0] 5 cycles after the start pulse -> eng_rst[0] high 4 cycles, eng_start[0] pulse at cycle 6 after the edge, finished=0x1, busy low afterwards.
REQ-041 The bench SHALL cover: cfg_start=0xF in one cycle, each engine done 3 cycles after its start -> grant order 0,1,2,3 and finished=0xF.
REQ-042 The bench SHALL cover: after engine 1 completes, new edges on bits 0 and 3 simultaneously -> engine 3 granted before engine 0.
REQ-043 The bench SHALL cover: engine 2 in WAIT, cfg_reset=0x4 for 1 cycle -> FSM returns to IDLE, finished[2]=0 and pending[2]=0.
REQ-044 The bench SHALL cover, with SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16: no done -> timeout=0x1 after 16 WAIT cycles, finished=0; without the macro, busy stays high.
REQ-045 The bench SHALL cover: cfg_start held at 0x1 across HRESET mid-WAIT -> all outputs clear, then an edge is detected after release and engine 0 is re-sequenced.

Source files
------------

// File: rtl/engine_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : engine_sequencer_if
// Description : Per-engine control bundle between the engine sequencer and
//               the engines it drives: reset, start pulse and completion.
// Revision    : 1.0 - initial release
// ============================================================================
interface engine_sequencer_if #(
    parameter int NUM_ENG = 4
) ();
    logic [NUM_ENG-1:0] eng_rst;
    logic [NUM_ENG-1:0] eng_start;
    logic [NUM_ENG-1:0] eng_done;

    // Sequencer side: drives reset/start, observes completion.
    modport master (output eng_rst, output eng_start, input eng_done);
    // Engine side: observes reset/start, reports completion.
    modport slave  (input eng_rst, input eng_start, output eng_done);
endinterface
`default_nettype wire

// File: rtl/engine_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : engine_sequencer
// Description : Round-robin sequencer sharing one datapath among NUM_ENG
//               engines. Each granted engine is held in reset, pulsed to
//               start, then awaited until done. Optional watchdog enabled by
//               defining SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module engine_sequencer #(
    parameter int NUM_ENG        = 4,
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire                HCLK,
    input  wire                HRESET,
    input  wire  [31:0]        cfg_reset,
    input  wire  [31:0]        cfg_start,
    engine_sequencer_if.master eng,
    output logic [31:0]        finished,
    output logic [31:0]        timeout,
    output logic               busy,
    output logic [4:0]         cur_eng
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [4:0] C_LAST_GRANT_RST = 5'(NUM_ENG - 1);
    localparam logic [7:0] C_RST_LAST       = 8'(RST_CYCLES - 1);

    // Parameter sanity: catch illegal configurations at elaboration.
    if (NUM_ENG < 1 || NUM_ENG > 32) begin : g_bad_num_eng
        $error("engine_sequencer: NUM_ENG must be 1..32");
    end
    if (RST_CYCLES < 1 || RST_CYCLES > 255) begin : g_bad_rst_cycles
        $error("engine_sequencer: RST_CYCLES must be 1..255");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("engine_sequencer: TIMEOUT_CYCLES must be 2..65535");
    end

    // Control bits above NUM_ENG have no engine behind them.
    if (NUM_ENG < 32) begin : g_unused_hi
        logic w_unused_hi;
        assign w_unused_hi = ^{cfg_reset[31:NUM_ENG], cfg_start[31:NUM_ENG]};
    end

    state_t             r_state, w_state_n;
    logic [4:0]         r_grant, w_grant_n;
    logic [4:0]         r_last_grant, w_last_grant_n;
    logic [7:0]         r_rst_cnt, w_rst_cnt_n;
    logic [NUM_ENG-1:0] r_start_prev, r_pending, w_pending_n;
    logic [NUM_ENG-1:0] r_finished, w_finished_n;
    logic [NUM_ENG-1:0] w_cfg_reset, w_cfg_start, w_start_edge;
    logic [NUM_ENG-1:0] w_grant_oh, w_req, w_req_hi, w_pick_oh;
    logic [4:0]         w_pick_hi, w_pick_any, w_pick;
    logic               w_abort, w_done_g;
`ifdef SEQ_TIMEOUT_EN
    localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [NUM_ENG-1:0] r_timeout, w_timeout_n;
    logic [15:0]        r_wd_cnt, w_wd_cnt_n;
`endif

    assign w_cfg_reset  = cfg_reset[NUM_ENG-1:0];
    assign w_cfg_start  = cfg_start[NUM_ENG-1:0];
    // A reset engine cannot be started: its edges are dropped here.
    assign w_start_edge = w_cfg_start & ~r_start_prev & ~w_cfg_reset;
    assign w_req        = r_pending & ~w_cfg_reset;

    // Round-robin pick: lowest request above last_grant, else lowest overall.
    always_comb begin
        w_grant_oh = '0;
        w_req_hi   = '0;
        w_pick_oh  = '0;
        w_pick_hi  = '0;
        w_pick_any = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            w_grant_oh[i] = (r_grant == 5'(i));
            w_req_hi[i]   = w_req[i] && (5'(i) > r_last_grant);
        end
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (w_req_hi[i]) w_pick_hi  = 5'(i);
            if (w_req[i])    w_pick_any = 5'(i);
        end
        w_pick = (|w_req_hi) ? w_pick_hi : w_pick_any;
        for (int i = 0; i < NUM_ENG; i++) begin
            w_pick_oh[i] = (w_pick == 5'(i));
        end
    end

    assign w_abort  = |(w_cfg_reset & w_grant_oh);
    assign w_done_g = |(eng.eng_done & w_grant_oh);

    // Next-state and bookkeeping; a reset of the granted engine aborts any phase.
    always_comb begin
        w_state_n      = r_state;
        w_grant_n      = r_grant;
        w_last_grant_n = r_last_grant;
        w_rst_cnt_n    = r_rst_cnt;
        w_pending_n    = (r_pending | w_start_edge) & ~w_cfg_reset;
        w_finished_n   = r_finished & ~w_start_edge & ~w_cfg_reset;
`ifdef SEQ_TIMEOUT_EN
        w_timeout_n    = r_timeout & ~w_start_edge & ~w_cfg_reset;
        w_wd_cnt_n     = r_wd_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (|w_req) begin
                    w_grant_n   = w_pick;
                    w_pending_n = w_pending_n & ~w_pick_oh;
                    w_rst_cnt_n = '0;
                    w_state_n   = S_RST;
                end
            end
            S_RST: begin
                if (w_abort) begin
                    w_state_n = S_IDLE;
                end else if (r_rst_cnt == C_RST_LAST) begin
                    w_state_n = S_START;
                end else begin
                    w_rst_cnt_n = r_rst_cnt + 8'd1;
                end
            end
            S_START: begin
                if (w_abort) begin
                    w_state_n = S_IDLE;
                end else begin
                    w_state_n = S_WAIT;
`ifdef SEQ_TIMEOUT_EN
                    w_wd_cnt_n = '0;
`endif
                end
            end
            S_WAIT: begin
                if (w_abort) begin
                    w_state_n = S_IDLE;
                end else if (w_done_g) begin
                    w_state_n = S_DONE;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (r_wd_cnt == C_TO_LAST) begin
                    w_timeout_n = w_timeout_n | w_grant_oh;
                    w_state_n   = S_IDLE;
                end else begin
                    w_wd_cnt_n = r_wd_cnt + 16'd1;
                end
`endif
            end
            S_DONE: begin
                if (!w_abort) begin
                    w_finished_n   = w_finished_n | w_grant_oh;
                    w_last_grant_n = r_grant;
                end
                w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= C_LAST_GRANT_RST;
            r_rst_cnt    <= '0;
            r_start_prev <= '0;
            r_pending    <= '0;
            r_finished   <= '0;
`ifdef SEQ_TIMEOUT_EN
            r_timeout    <= '0;
            r_wd_cnt     <= '0;
`endif
        end else begin
            r_state      <= w_state_n;
            r_grant      <= w_grant_n;
            r_last_grant <= w_last_grant_n;
            r_rst_cnt    <= w_rst_cnt_n;
            r_start_prev <= w_cfg_start;
            r_pending    <= w_pending_n;
            r_finished   <= w_finished_n;
`ifdef SEQ_TIMEOUT_EN
            r_timeout    <= w_timeout_n;
            r_wd_cnt     <= w_wd_cnt_n;
`endif
        end
    end

    assign eng.eng_rst   = HRESET ? {NUM_ENG{1'b1}}
                                  : (w_cfg_reset | ((r_state == S_RST) ? w_grant_oh : '0));
    assign eng.eng_start = (r_state == S_START) ? w_grant_oh : '0;
    assign busy          = (r_state != S_IDLE);
    assign cur_eng       = (r_state == S_IDLE) ? 5'd0 : r_grant;
    assign finished      = 32'(r_finished);
`ifdef SEQ_TIMEOUT_EN
    assign timeout       = 32'(r_timeout);
`else
    assign timeout       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_engine_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_engine_sequencer
// Description : Scoreboard bench for engine_sequencer (4 engines, 4 reset
//               cycles, watchdog limit 16 when SEQ_TIMEOUT_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_engine_sequencer;

    localparam int RST_CYCLES = 4;

    typedef struct { int eng; int cyc; } start_exp_t;
    typedef struct { logic [31:0] fin; logic [31:0] to; int cyc; } end_exp_t;

    logic        HCLK;
    logic        HRESET;
    logic [31:0] cfg_reset;
    logic [31:0] cfg_start;
    logic [31:0] finished;
    logic [31:0] timeout;
    logic        busy;
    logic [4:0]  cur_eng;

    engine_sequencer_if #(.NUM_ENG(4)) eng_if ();

    engine_sequencer #(
        .NUM_ENG        (4),
        .RST_CYCLES     (RST_CYCLES),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .cfg_reset (cfg_reset),
        .cfg_start (cfg_start),
        .eng       (eng_if),
        .finished  (finished),
        .timeout   (timeout),
        .busy      (busy),
        .cur_eng   (cur_eng)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         done_delay = 0;
    start_exp_t q_start[$];
    end_exp_t   q_end[$];

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (k < budget && !(busy === 1'b0 && q_start.size() == 0 && q_end.size() == 0)) begin
            @(negedge HCLK);
            #1;
            k++;
        end
        check(name, 32'(k < budget), 32'd1);
        @(posedge HCLK);
        #1;
    endtask

    task automatic wait_start(input string name, input int budget);
        int k;
        k = 0;
        while (k < budget && eng_if.eng_start === 4'b0) begin
            @(negedge HCLK);
            #1;
            k++;
        end
        check(name, 32'(k < budget), 32'd1);
    endtask

    // Engine model: answer a start pulse with a 1-cycle done after done_delay cycles.
    initial begin
        logic [3:0] m;
        eng_if.eng_done = '0;
        forever begin
            @(negedge HCLK);
            if (eng_if.eng_start !== 4'b0 && done_delay > 0) begin
                m = eng_if.eng_start;
                repeat (done_delay) @(posedge HCLK);
                #1 eng_if.eng_done = m;
                @(posedge HCLK);
                #1 eng_if.eng_done = '0;
            end
        end
    end

    // Monitor: start pulses and sequence ends are checked against the queues.
    initial begin
        int         run[4];
        int         last_run[4];
        logic       prev_busy;
        start_exp_t se;
        end_exp_t   ee;
        for (int i = 0; i < 4; i++) begin
            run[i]      = 0;
            last_run[i] = 0;
        end
        prev_busy = 1'b0;
        forever begin
            @(negedge HCLK);
            for (int i = 0; i < 4; i++) begin
                if (eng_if.eng_rst[i] === 1'b1) begin
                    run[i]++;
                end else begin
                    if (run[i] != 0) last_run[i] = run[i];
                    run[i] = 0;
                end
            end
            if (eng_if.eng_start !== 4'b0) begin
                if (q_start.size() == 0) begin
                    check("unexpected_start", 32'(eng_if.eng_start), 32'd0);
                end else begin
                    se = q_start.pop_front();
                    check("start_onehot", 32'(eng_if.eng_start), 32'd1 << se.eng);
                    check("start_cur_eng", 32'(cur_eng), 32'(se.eng));
                    check("start_rst_len", 32'(last_run[se.eng]), 32'(RST_CYCLES));
                    if (se.cyc >= 0) check("start_cycle", 32'(cyc), 32'(se.cyc));
                end
            end
            if (prev_busy === 1'b1 && busy === 1'b0) begin
                if (q_end.size() == 0) begin
                    check("unexpected_end", finished, 32'hFFFF_FFFF);
                end else begin
                    ee = q_end.pop_front();
                    check("end_finished", finished, ee.fin);
                    check("end_timeout", timeout, ee.to);
                    if (ee.cyc >= 0) check("end_cycle", 32'(cyc), 32'(ee.cyc));
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: got no finish, expected finish before 200000");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int t0;
        HRESET    = 1'b1;
        cfg_reset = '0;
        cfg_start = '0;

        // Reset state
        tick(3);
        @(negedge HCLK);
        check("rst_eng_rst", 32'(eng_if.eng_rst), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur_eng", 32'(cur_eng), 32'd0);
        check("rst_finished", finished, 32'd0);
        check("rst_timeout", timeout, 32'd0);
        check("rst_eng_start", 32'(eng_if.eng_start), 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        tick(2);
        @(negedge HCLK);
        check("rel_eng_rst", 32'(eng_if.eng_rst), 32'd0);
        @(posedge HCLK); #1;

        // Single engine, done 5 cycles after start
        done_delay = 5;
        cfg_start  = 32'h1;
        t0 = cyc;
        q_start.push_back('{0, t0 + 6});
        q_end.push_back('{32'h1, 32'h0, t0 + 13});
        wait_idle("t1_complete", 60);
        check("t1_finished", finished, 32'h1);
        check("t1_busy", 32'(busy), 32'd0);
        cfg_start = '0;
        tick(1);

        // Fresh reset, then all four at once: order 0,1,2,3
        HRESET = 1'b1;
        tick(2);
        @(negedge HCLK);
        check("r2_finished", finished, 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        tick(1);
        done_delay = 3;
        cfg_start  = 32'hF;
        t0 = cyc;
        for (int i = 0; i < 4; i++) q_start.push_back('{i, (i == 0) ? t0 + 6 : -1});
        q_end.push_back('{32'h1, 32'h0, -1});
        q_end.push_back('{32'h3, 32'h0, -1});
        q_end.push_back('{32'h7, 32'h0, -1});
        q_end.push_back('{32'hF, 32'h0, -1});
        wait_idle("t2_complete", 200);
        cfg_start = '0;
        tick(1);

        // Engine 1 completes, then 0 and 3 together: 3 wins round-robin
        cfg_start = 32'h2;
        q_start.push_back('{1, -1});
        q_end.push_back('{32'hF, 32'h0, -1});
        wait_idle("t3a_complete", 60);
        cfg_start = 32'hB;
        q_start.push_back('{3, -1});
        q_start.push_back('{0, -1});
        q_end.push_back('{32'hE, 32'h0, -1});
        q_end.push_back('{32'hF, 32'h0, -1});
        wait_idle("t3b_complete", 100);
        cfg_start = '0;
        tick(1);

        // Engine 2 aborted by cfg_reset while waiting
        done_delay = 0;
        cfg_start  = 32'h4;
        q_start.push_back('{2, -1});
        q_end.push_back('{32'hB, 32'h0, -1});
        wait_start("t4_start_seen", 40);
        tick(2);
        cfg_reset = 32'h4;
        @(negedge HCLK);
        check("t4_eng_rst", 32'(eng_if.eng_rst), 32'h4);
        @(posedge HCLK); #1;
        cfg_reset = '0;
        wait_idle("t4_abort", 20);
        tick(8);
        check("t4_no_restart", 32'(busy), 32'd0);
        check("t4_finished", finished, 32'hB);
        cfg_start = '0;
        tick(1);

        // Reset and start edge in the same cycle: reset wins
        cfg_reset = 32'h1;
        cfg_start = 32'h1;
        tick(1);
        cfg_reset = '0;
        tick(8);
        check("t5_reset_wins_busy", 32'(busy), 32'd0);
        check("t5_reset_wins_fin", finished, 32'hA);
        cfg_start = '0;
        tick(1);

        // No done from engine 0: watchdog or indefinite wait
        cfg_start = 32'h1;
        t0 = cyc;
        q_start.push_back('{0, t0 + 6});
`ifdef SEQ_TIMEOUT_EN
        q_end.push_back('{32'hA, 32'h1, t0 + 23});
        wait_idle("t6_timeout_end", 80);
        check("t6_timeout", timeout, 32'h1);
        check("t6_finished", finished, 32'hA);
        cfg_start = '0;
        tick(1);
        cfg_start = 32'h1;
        t0 = cyc;
        q_start.push_back('{0, t0 + 6});
        tick(10);
`else
        tick(40);
        check("t6_busy_held", 32'(busy), 32'd1);
        check("t6_timeout_zero", timeout, 32'd0);
`endif

        // HRESET mid-WAIT with cfg_start held high
        q_end.push_back('{32'h0, 32'h0, -1});
        HRESET = 1'b1;
        tick(1);
        @(negedge HCLK);
        check("t7_rst_eng_rst", 32'(eng_if.eng_rst), 32'hF);
        check("t7_rst_busy", 32'(busy), 32'd0);
        check("t7_rst_finished", finished, 32'd0);
        check("t7_rst_timeout", timeout, 32'd0);
        check("t7_rst_cur_eng", 32'(cur_eng), 32'd0);
        check("t7_rst_eng_start", 32'(eng_if.eng_start), 32'd0);
        @(posedge HCLK); #1;
        HRESET     = 1'b0;
        done_delay = 3;
        t0 = cyc;
        q_start.push_back('{0, t0 + 6});
        q_end.push_back('{32'h1, 32'h0, t0 + 11});
        wait_idle("t7_resequence", 60);
        check("t7_finished", finished, 32'h1);

        check("queues_drained", 32'(q_start.size() + q_end.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
